// File: rtl/sqrt_iter_if.sv
// Operand/result handshake bundle for sqrt_iter; the unit is the slave.
// Input side is valid/ready with in_data, output side is valid/ready with root/rem/exact.
interface sqrt_iter_if #(
    parameter int WIDTH = 8
);
    localparam int HALF = WIDTH / 2;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [HALF-1:0]   out_root;
    logic [HALF:0]     out_rem;
    logic              out_exact;
    logic              busy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_root, out_rem, out_exact, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_root, out_rem, out_exact, busy
    );
endinterface

// File: rtl/sqrt_iter.sv
// Restoring bit-serial integer square root: one root bit per clock, HALF+1 cycles accept-to-result.
// Single operand in flight; result is held in DONE until out_ready, and no new operand is taken meanwhile.
module sqrt_iter #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    sqrt_iter_if.slave  bus
);
    localparam int HALF = WIDTH / 2;
    localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;

    if ((WIDTH % 2 != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("sqrt_iter: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [HALF-1:0]  r_v;
    logic [WIDTH-1:0] r_r;
    logic [IW-1:0]    r_i;
    logic [HALF-1:0]  r_root;
    logic [HALF:0]    r_rem;
    logic             r_exact;

    logic [WIDTH:0]   w_r_ext;
    logic [WIDTH:0]   w_v_ext;
    logic [WIDTH:0]   w_tt;
    logic [IW:0]      w_sh;
    logic [IW:0]      w_sh2;
    logic             w_take;
    logic [HALF-1:0]  w_v_next;
    logic [WIDTH-1:0] w_r_next;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;

    // Trial value tt = (v << (i+1)) | (1 << 2i), kept WIDTH+1 bits so the top trial never truncates.
    always_comb begin
        w_r_ext  = {1'b0, r_r};
        w_v_ext  = (WIDTH+1)'(r_v);
        w_sh     = {1'b0, r_i} + 1'b1;
        w_sh2    = {r_i, 1'b0};
        w_tt     = (w_v_ext << w_sh) | ((WIDTH+1)'(1) << w_sh2);
        w_take   = (w_tt <= w_r_ext);
        w_v_next = r_v;
        w_r_next = r_r;
        if (w_take) begin
            w_v_next[r_i] = 1'b1;
            w_r_next      = r_r - w_tt[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (r_i == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Result registers load on the last iteration so out_* stay frozen through IDLE and CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v     <= '0;
            r_r     <= '0;
            r_i     <= '0;
            r_root  <= '0;
            r_rem   <= '0;
            r_exact <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_r <= bus.in_data;
                        r_v <= '0;
                        r_i <= IW'(HALF - 1);
                    end
                end
                S_CALC: begin
                    r_v <= w_v_next;
                    r_r <= w_r_next;
                    if (r_i == '0) begin
                        r_root  <= w_v_next;
                        r_rem   <= w_r_next[HALF:0];
                        r_exact <= (w_r_next == '0);
                    end else begin
                        r_i <= r_i - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.out_root  = r_root;
    assign bus.out_rem   = r_rem;
    assign bus.out_exact = r_exact;
endmodule

// File: tb/tb_sqrt_iter.sv
// Bench for sqrt_iter at WIDTH=8 and WIDTH=16: directed corners, exhaustive 8-bit sweep, random 16-bit operands.
module tb_sqrt_iter;
    logic clk = 1'b0;
    logic rst8;
    logic rst16;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sqrt_iter_if #(.WIDTH(8))  if8 ();
    sqrt_iter_if #(.WIDTH(16)) if16 ();

    sqrt_iter #(.WIDTH(8))  u8  (.clk(clk), .rst(rst8),  .bus(if8.slave));
    sqrt_iter #(.WIDTH(16)) u16 (.clk(clk), .rst(rst16), .bus(if16.slave));

    function automatic int unsigned isqrt(input int unsigned a);
        int unsigned x = 0;
        while ((x + 1) * (x + 1) <= a) x++;
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit w, input logic v, input logic [31:0] d);
        if (w) begin
            if16.in_valid = v;
            if16.in_data  = d[15:0];
        end else begin
            if8.in_valid = v;
            if8.in_data  = d[7:0];
        end
    endtask

    task automatic set_ordy(input bit w, input logic v);
        if (w) if16.out_ready = v;
        else   if8.out_ready  = v;
    endtask

    task automatic snap(input bit w, output logic vld, output logic rdy, output logic bsy,
                        output logic ex, output logic [31:0] root, output logic [31:0] rem);
        if (w) begin
            vld = if16.out_valid; rdy = if16.in_ready; bsy = if16.busy;
            ex = if16.out_exact; root = 32'(if16.out_root); rem = 32'(if16.out_rem);
        end else begin
            vld = if8.out_valid; rdy = if8.in_ready; bsy = if8.busy;
            ex = if8.out_exact; root = 32'(if8.out_root); rem = 32'(if8.out_rem);
        end
    endtask

    task automatic check_idle_clear(input bit w, input string tag);
        logic vld, rdy, bsy, ex;
        logic [31:0] root, rem;
        snap(w, vld, rdy, bsy, ex, root, rem);
        chk({tag, "_out_valid"}, 32'(vld), 0);
        chk({tag, "_in_ready"},  32'(rdy), 1);
        chk({tag, "_busy"},      32'(bsy), 0);
        chk({tag, "_root"},      root,     0);
        chk({tag, "_rem"},       rem,      0);
        chk({tag, "_exact"},     32'(ex),  0);
    endtask

    // Present one operand, return at the falling edge just after the accepting edge.
    task automatic start(input bit w, input int unsigned a);
        logic vld, rdy, bsy, ex;
        logic [31:0] root, rem;
        @(negedge clk);
        set_in(w, 1'b1, a);
        snap(w, vld, rdy, bsy, ex, root, rem);
        chk("accept_in_ready", 32'(rdy), 1);
        @(posedge clk);
        @(negedge clk);
        set_in(w, 1'b0, $urandom);
    endtask

    task automatic wait_done(input bit w, output int cnt);
        logic vld, rdy, bsy, ex;
        logic [31:0] root, rem;
        cnt = 1;
        snap(w, vld, rdy, bsy, ex, root, rem);
        while (!vld && cnt < 64) begin
            @(negedge clk);
            cnt++;
            snap(w, vld, rdy, bsy, ex, root, rem);
        end
    endtask

    task automatic check_res(input bit w, input int unsigned a, input int cnt, input int exp_lat);
        logic vld, rdy, bsy, ex;
        logic [31:0] root, rem;
        int unsigned m_root, m_rem;
        m_root = isqrt(a);
        m_rem  = a - m_root * m_root;
        snap(w, vld, rdy, bsy, ex, root, rem);
        chk("latency",   cnt,      exp_lat);
        chk("out_valid", 32'(vld), 1);
        chk("root",      root,     m_root);
        chk("rem",       rem,      m_rem);
        chk("exact",     32'(ex),  (m_rem == 0) ? 1 : 0);
    endtask

    task automatic consume(input bit w);
        logic vld, rdy, bsy, ex;
        logic [31:0] root, rem;
        set_ordy(w, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ordy(w, 1'b0);
        snap(w, vld, rdy, bsy, ex, root, rem);
        chk("consumed_out_valid", 32'(vld), 0);
        chk("consumed_in_ready",  32'(rdy), 1);
    endtask

    task automatic op(input bit w, input int unsigned a, input int hold);
        int cnt;
        logic vld, rdy, bsy, ex;
        logic [31:0] root, rem;
        int unsigned m_root;
        start(w, a);
        wait_done(w, cnt);
        check_res(w, a, cnt, (w ? 8 : 4) + 1);
        if (hold > 0) begin
            set_ordy(w, 1'b0);
            repeat (hold) @(negedge clk);
            m_root = isqrt(a);
            snap(w, vld, rdy, bsy, ex, root, rem);
            chk("held_out_valid", 32'(vld), 1);
            chk("held_in_ready",  32'(rdy), 0);
            chk("held_root",      root,     m_root);
            chk("held_rem",       rem,      a - m_root * m_root);
        end
        consume(w);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic vld, rdy, bsy, ex;
        logic [31:0] root, rem;
        int cnt;
        int seen;

        rst8 = 1'b1;
        rst16 = 1'b1;
        set_in(1'b0, 1'b0, 0);
        set_in(1'b1, 1'b0, 0);
        set_ordy(1'b0, 1'b0);
        set_ordy(1'b1, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst8 = 1'b0;
        rst16 = 1'b0;
        check_idle_clear(1'b0, "reset8");
        check_idle_clear(1'b1, "reset16");

        op(1'b0, 144, 0);
        op(1'b0, 143, 0);
        op(1'b0, 0, 0);
        op(1'b0, 255, 0);
        op(1'b0, 200, 10);

        // Reset lands on the second CALC edge; the operand must vanish without a result.
        start(1'b0, 99);
        @(posedge clk);
        @(negedge clk);
        rst8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst8 = 1'b0;
        check_idle_clear(1'b0, "midcalc_rst");
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            snap(1'b0, vld, rdy, bsy, ex, root, rem);
            if (vld) seen = 1;
        end
        chk("no_result_after_rst", seen, 0);
        op(1'b0, 81, 0);

        set_ordy(1'b0, 1'b1);
        for (int a = 0; a < 256; a++) op(1'b0, a, 0);
        set_ordy(1'b0, 1'b0);

        op(1'b1, 65535, 0);
        op(1'b1, 65025, 0);
        for (int k = 0; k < 40; k++) op(1'b1, $urandom_range(0, 65535), $urandom_range(0, 3));

        start(1'b1, 50000);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            set_in(1'b1, (k % 2 == 0), $urandom);
            snap(1'b1, vld, rdy, bsy, ex, root, rem);
            chk("toggle_busy", 32'(bsy), 1);
            chk("toggle_in_ready", 32'(rdy), 0);
        end
        set_in(1'b1, 1'b0, 0);
        wait_done(1'b1, cnt);
        check_res(1'b1, 50000, cnt, 3);
        consume(1'b1);

        start(1'b1, 1234);
        wait_done(1'b1, cnt);
        check_res(1'b1, 1234, cnt, 9);
        set_ordy(1'b1, 1'b1);
        rst16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst16 = 1'b0;
        set_ordy(1'b1, 1'b0);
        check_idle_clear(1'b1, "rst_and_ordy");
        op(1'b1, 4096, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sqrt_iter.md
Name: sqrt_iter

Overview:
- Sequential, parametrised integer square root unit.
- Input: unsigned operand of WIDTH bits. Outputs: floor root (WIDTH/2 bits), error remainder (operand - root^2), and an exact flag.
- Restoring bit-serial algorithm, one root bit per clock, with valid/ready handshakes on input and output.
- Multi-cycle successor to the combinational sqrt/error pair. Intended for datapaths where a full combinational tree or EAB lookup is too large, e.g. WIDTH 16..32.

Parameters:
- WIDTH, 8: operand width in bits. Must be even and >= 4. The generic elaborates $error otherwise.
- HALF, WIDTH/2: derived, not overridable. Root width and iteration count.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- in_valid, input, 1: operand presented.
- in_ready, output, 1: unit can accept an operand.
- in_data, input, WIDTH: unsigned operand a.
- out_valid, output, 1: result held on the out_* bus.
- out_ready, input, 1: consumer accepts the result.
- out_root, output, HALF: floor(sqrt(a)).
- out_rem, output, HALF+1: a - out_root^2. Always <= 2*out_root.
- out_exact, output, 1: 1 when out_rem == 0.
- busy, output, 1: state is CALC.

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - out_root=0, out_rem=0, out_exact=0. Internal v, r and the bit index are cleared.
  - Reset takes priority over every other event, including mid-CALC and held DONE. Any in-flight operand is discarded with no output.
- States:
  - IDLE: in_ready=1. On an edge with in_valid=1: r <= in_data, v <= 0, i <= HALF-1, go to CALC.
  - CALC: in_ready=0, busy=1. On each edge:
    - tt = (v << (i+1)) | (1 << 2i), computed WIDTH+1 bits wide so no truncation.
    - If tt <= r: v[i] <= 1 and r <= r - tt.
    - If i == 0, go to DONE; else i <= i-1.
  - DONE: out_valid=1. out_root=v, out_rem=r[HALF:0], out_exact=(r==0). in_ready=0.
    - On an edge with out_ready=1: go to IDLE and drop out_valid.
    - Otherwise hold every out_* bit stable.
- Latency:
  - Operand accepted at edge T. Iterations occur at edges T+1..T+HALF.
  - out_valid is high in the cycle after edge T+HALF. That is HALF+1 cycles accept-to-result (5 for WIDTH=8).
  - Minimum issue interval is HALF+2 cycles, since the return to IDLE costs one edge.
  - No skid: a new operand is never accepted in the same edge that a result is consumed.
- Handshake rules:
  - A transfer occurs only on an edge where valid and ready are both 1.
  - in_data is ignored outside IDLE.
  - in_valid may drop without being accepted; no state is retained.
  - out_ready is ignored outside DONE.
  - out_valid, once high, stays high until consumed or reset.
- Outputs in IDLE/CALC: out_root, out_rem and out_exact hold the last delivered result (0 after reset). They are only meaningful while out_valid=1.
- Arithmetic:
  - All values are unsigned.
  - r never goes negative: subtraction happens only when tt <= r.
  - The final remainder satisfies r <= 2v, so HALF+1 bits suffice. Upper bits of r are zero at DONE, and the checker asserts this.
- Boundaries:
  - a=0 gives root 0, rem 0, exact 1.
  - a=2^WIDTH-1 gives root 2^HALF-1, rem 2^(HALF+1)-2. This is the maximum remainder and must not overflow.
  - Simultaneous reset with in_valid or out_ready: reset wins.
- Implementation: fully synchronous, no latches, no combinational path from in_* to out_*. Only in_ready/out_valid decode from the state register. Target <= 1 subtractor + 1 comparator of WIDTH+1 bits.

Test Plan:
- Reset behaviour (WIDTH=8): assert rst 2 cycles, then release -> in_ready=1, out_valid=0, busy=0, out_root=0, out_rem=0.
- Basic results (WIDTH=8): a=144 -> root 12, rem 0, exact 1. a=143 -> root 11, rem 22, exact 0. a=0 -> 0/0/exact. a=255 -> root 15, rem 30. Each out_valid rises exactly 5 cycles after acceptance.
- Output backpressure (WIDTH=8): a=200, hold out_ready=0 for 10 cycles -> out_valid stays 1, root 14, rem 4 stable, in_ready=0. Pulse out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-calculation (WIDTH=8): accept a=99, assert rst at the 2nd CALC edge -> no out_valid ever appears for 99. The next operand a=81 -> root 9, rem 0.
- Wide exhaustive and corner checks:
  - WIDTH=8 exhaustive: all 256 operands back-to-back with out_ready=1 -> compare against the reference model root^2 <= a < (root+1)^2 and rem = a - root^2.
  - WIDTH=16: a=65535 -> root 255, rem 510.
  - WIDTH=16: a=65025 -> root 255, rem 0.
- Handshake corners (WIDTH=16):
  - in_valid toggling during CALC -> ignored, busy stays 1.
  - Simultaneous rst and out_ready in DONE -> IDLE with out_valid=0, outputs cleared.
